// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier for the EX stage: a mul opcode stalls the pipe
// for WIDTH iterations, then presents the low WIDTH product bits for one cycle.
module alu_mul_seq #(
  parameter int         WIDTH    = 32,
  parameter logic [2:0] MUL_CODE = 3'b101,
  parameter int         CNT_W    = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CNT_W-1:0] cnt;
  logic             mul_req;

  assign mul_req  = start_i && (ALUCtrl_i == MUL_CODE);
  assign acc_next = mplier[0] ? (acc + mcand) : acc;

  // A flush or reset arriving together with a mul request suppresses the accept,
  // so the stall must not be raised for it either.
  assign stall_o = ((state == IDLE) && mul_req && !flush_i && !rst_i) || (state == BUSY);
  assign ready_o = (state == IDLE);
  assign zero_o  = (data_o == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      data_o  <= '0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (mul_req && !flush_i) begin
            mcand  <= data1_i;
            mplier <= data2_i;
            acc    <= '0;
            cnt    <= '0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (flush_i) begin
            state <= IDLE;
          end else begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
            // The final partial product lands in data_o on the same edge it is added.
            if (cnt == CNT_W'(WIDTH - 1)) begin
              data_o  <= acc_next;
              valid_o <= 1'b1;
              state   <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq: products are queued on issue and checked
// by a monitor whenever valid_o pulses.
module tb_alu_mul_seq;

  localparam int         WIDTH = 32;
  localparam logic [2:0] MUL   = 3'b101;
  localparam logic [2:0] ADD   = 3'b011;

  logic             clk_i;
  logic             rst_i;
  logic             start_i;
  logic [2:0]       ALUCtrl_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic             flush_i;
  logic             stall_o;
  logic             ready_o;
  logic             valid_o;
  logic [WIDTH-1:0] data_o;
  logic             zero_o;

  int               check_count = 0;
  int               error_count = 0;
  logic [WIDTH-1:0] sb[$];
  logic [WIDTH-1:0] exp_data;

  alu_mul_seq #(.WIDTH(WIDTH), .MUL_CODE(MUL)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .ALUCtrl_i(ALUCtrl_i),
    .data1_i  (data1_i),
    .data2_i  (data2_i),
    .flush_i  (flush_i),
    .stall_o  (stall_o),
    .ready_o  (ready_o),
    .valid_o  (valid_o),
    .data_o   (data_o),
    .zero_o   (zero_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic [2:0] ctrl,
                               input logic [31:0] a, input logic [31:0] b, input logic flush);
    @(posedge clk_i);
    #1;
    start_i   = start;
    ALUCtrl_i = ctrl;
    data1_i   = a;
    data2_i   = b;
    flush_i   = flush;
  endtask

  // Every valid_o pulse must match the oldest outstanding product.
  always @(negedge clk_i) begin
    if (!rst_i && valid_o) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_valid", 32'(valid_o), 32'd0);
      end else begin
        logic [WIDTH-1:0] exp;
        exp = sb.pop_front();
        checkOutput("product", data_o, exp);
        checkOutput("zero_flag", 32'(zero_o), 32'(exp == '0));
      end
    end
  end

  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input bit hold);
    int n;
    bit seen;
    bit stall_bad;
    logic [31:0] prod;
    prod = a * b;
    applyStimulus(1'b1, MUL, a, b, 1'b0);
    sb.push_back(prod);
    @(negedge clk_i);
    checkOutput("accept_stall", 32'(stall_o), 32'd1);
    checkOutput("accept_ready", 32'(ready_o), 32'd1);
    n = 0;
    seen = 1'b0;
    stall_bad = 1'b0;
    while (!seen && n < 40) begin
      n++;
      @(posedge clk_i);
      #1;
      if (n == 1) begin
        if (!hold) begin
          start_i = 1'b0;
        end else begin
          data1_i = ~a;
          data2_i = a ^ b ^ 32'h5a5a_1234;
        end
      end
      @(negedge clk_i);
      if (valid_o) seen = 1'b1;
      else if (!stall_o || ready_o) stall_bad = 1'b1;
    end
    if (!seen) begin
      checkOutput("valid_timeout", 32'd0, 32'd1);
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      checkOutput("latency", 32'(n), 32'd33);
      checkOutput("done_stall", 32'(stall_o), 32'd0);
      exp_data = prod;
    end
    checkOutput("busy_stall", 32'(stall_bad), 32'd0);
    if (!hold) begin
      @(posedge clk_i);
      #1;
      @(negedge clk_i);
      checkOutput("post_ready", 32'(ready_o), 32'd1);
      checkOutput("post_valid", 32'(valid_o), 32'd0);
      checkOutput("post_data", data_o, exp_data);
    end
  endtask

  // Abort an in-flight multiply with flush_i or rst_i in cycle T+at.
  task automatic run_abort(input logic [31:0] a, input logic [31:0] b, input int at, input bit use_reset);
    bit seen;
    applyStimulus(1'b1, MUL, a, b, 1'b0);
    @(negedge clk_i);
    for (int n = 1; n <= at; n++) begin
      @(posedge clk_i);
      #1;
      if (n == 1) start_i = 1'b0;
      if (n == at) begin
        if (use_reset) rst_i = 1'b1;
        else flush_i = 1'b1;
      end
      @(negedge clk_i);
    end
    if (!use_reset) checkOutput("flush_stall", 32'(stall_o), 32'd1);
    @(posedge clk_i);
    #1;
    rst_i   = 1'b0;
    flush_i = 1'b0;
    @(negedge clk_i);
    if (use_reset) exp_data = '0;
    checkOutput("abort_ready", 32'(ready_o), 32'd1);
    checkOutput("abort_stall", 32'(stall_o), 32'd0);
    checkOutput("abort_data", data_o, exp_data);
    checkOutput("abort_zero", 32'(zero_o), 32'(exp_data == '0));
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk_i);
      if (valid_o) seen = 1'b1;
    end
    checkOutput("abort_no_valid", 32'(seen), 32'd0);
  endtask

  initial begin
    rst_i     = 1'b1;
    start_i   = 1'b0;
    ALUCtrl_i = 3'b000;
    data1_i   = '0;
    data2_i   = '0;
    flush_i   = 1'b0;
    exp_data  = '0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("reset_ready", 32'(ready_o), 32'd1);
    checkOutput("reset_stall", 32'(stall_o), 32'd0);
    checkOutput("reset_valid", 32'(valid_o), 32'd0);
    checkOutput("reset_data", data_o, 32'd0);
    checkOutput("reset_zero", 32'(zero_o), 32'd1);

    run_mul(32'd7, 32'd6, 1'b0);
    run_mul(32'hFFFF_FFFD, 32'd5, 1'b0);
    run_mul(32'h0001_0000, 32'h0001_0000, 1'b0);

    applyStimulus(1'b1, ADD, 32'd11, 32'd22, 1'b0);
    @(negedge clk_i);
    checkOutput("add_stall", 32'(stall_o), 32'd0);
    repeat (2) @(negedge clk_i);
    checkOutput("add_ready", 32'(ready_o), 32'd1);
    checkOutput("add_valid", 32'(valid_o), 32'd0);
    checkOutput("add_data", data_o, exp_data);
    applyStimulus(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);

    run_mul(32'd9, 32'd9, 1'b0);
    run_abort(32'd123, 32'd456, 10, 1'b0);
    run_mul(32'd3, 32'd3, 1'b0);

    applyStimulus(1'b1, MUL, 32'd77, 32'd77, 1'b1);
    @(negedge clk_i);
    checkOutput("flush_idle_stall", 32'(stall_o), 32'd0);
    applyStimulus(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    @(negedge clk_i);
    checkOutput("flush_idle_ready", 32'(ready_o), 32'd1);

    run_abort(32'd1000, 32'd1000, 15, 1'b1);

    run_mul(32'h1234_5678, 32'h0000_0010, 1'b1);
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    applyStimulus(1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    @(negedge clk_i);
    checkOutput("b2b_ready", 32'(ready_o), 32'd1);
    checkOutput("b2b_data", data_o, 32'h0000_0001);

    for (int i = 0; i < 3; i++) begin
      run_mul($urandom, $urandom, 1'b0);
    end

    repeat (3) @(negedge clk_i);
    checkOutput("sb_drain", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
